// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches the reference delay that aligns to the slicer
// output, locks on it, and accumulates bit/error counts while locked.
`timescale 1ns/1ps
module ber_checker #(
  parameter int MAX_LATENCY    = 32,
  parameter int NB_LATENCY     = 5,
  parameter int NB_WINDOW      = 8,
  parameter int SEARCH_ERR_THR = 8,
  parameter int LOL_ERR_THR    = 64,
  parameter int NB_COUNT       = 64
) (
  input  logic                  clock,
  input  logic                  in_reset,
  input  logic                  i_enable,
  input  logic                  i_ref_bit,
  input  logic                  i_rx_bit,
  input  logic                  i_clear_counters,
  output logic                  o_lock,
  output logic [NB_LATENCY-1:0] o_latency,
  output logic [NB_COUNT-1:0]   o_err_count,
  output logic [NB_COUNT-1:0]   o_bit_count
);

  typedef enum logic {SEARCH, LOCK} state_t;

  localparam logic [NB_WINDOW:0]    SRCH_THR = (NB_WINDOW+1)'(SEARCH_ERR_THR);
  localparam logic [NB_WINDOW:0]    LOL_THR  = (NB_WINDOW+1)'(LOL_ERR_THR);
  localparam logic [NB_LATENCY-1:0] LAT_MAX  = NB_LATENCY'(MAX_LATENCY-1);

  state_t                  state, state_nxt;
  logic [MAX_LATENCY-2:0]  dline;
  logic [MAX_LATENCY-1:0]  taps;
  logic [NB_WINDOW-1:0]    win_cnt, win_cnt_nxt;
  logic [NB_WINDOW:0]      win_err, win_err_nxt, win_err_tot;
  logic [NB_LATENCY-1:0]   lat_nxt, lat_inc;
  logic [NB_COUNT-1:0]     errc_nxt, bitc_nxt;
  logic                    err, win_last;

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v);
    return (&v) ? v : v + NB_COUNT'(1);
  endfunction

  // Tap 0 is the live reference bit; the register holds the older samples.
  assign taps        = {dline, i_ref_bit};
  assign err         = i_enable & (i_rx_bit ^ taps[o_latency]);
  assign win_err_tot = win_err + {{NB_WINDOW{1'b0}}, err};
  assign win_last    = &win_cnt;
  assign lat_inc     = (o_latency == LAT_MAX) ? '0 : o_latency + NB_LATENCY'(1);
  assign o_lock      = (state == LOCK);

  always_comb begin
    state_nxt   = state;
    lat_nxt     = o_latency;
    errc_nxt    = o_err_count;
    bitc_nxt    = o_bit_count;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    if (i_enable) begin
      win_cnt_nxt = win_cnt + NB_WINDOW'(1);
      win_err_nxt = win_err_tot;
      if (state == LOCK) begin
        bitc_nxt = sat_inc(o_bit_count);
        if (err) errc_nxt = sat_inc(o_err_count);
      end
      if (win_last) begin
        win_cnt_nxt = '0;
        win_err_nxt = '0;
        case (state)
          SEARCH: begin
            if (win_err_tot <= SRCH_THR) begin
              state_nxt = LOCK;
              errc_nxt  = '0;
              bitc_nxt  = '0;
            end else begin
              lat_nxt = lat_inc;
            end
          end
          LOCK: begin
            if (win_err_tot > LOL_THR) begin
              state_nxt = SEARCH;
              lat_nxt   = lat_inc;
            end
          end
          default: state_nxt = SEARCH;
        endcase
      end
    end
    // Clear wins over any increment on the same edge.
    if (i_clear_counters) begin
      errc_nxt = '0;
      bitc_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (in_reset) begin
      state       <= SEARCH;
      o_latency   <= '0;
      o_err_count <= '0;
      o_bit_count <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      dline       <= '0;
    end else begin
      state       <= state_nxt;
      o_latency   <= lat_nxt;
      o_err_count <= errc_nxt;
      o_bit_count <= bitc_nxt;
      win_cnt     <= win_cnt_nxt;
      win_err     <= win_err_nxt;
      if (i_enable) dline <= taps[MAX_LATENCY-2:0];
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: lock acquisition, error counting, clear priority,
// loss-of-lock and relock, counter saturation, reset and enable gating.
`timescale 1ns/1ps
module tb_ber_checker;

  logic        clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_ref_bit = 1'b0;
  logic        i_rx_bit = 1'b0;
  logic        i_clear_counters = 1'b0;
  logic        i_rx2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        o_lock, o_lock2;
  logic [4:0]  o_latency, o_latency2;
  logic [63:0] o_err_count, o_bit_count;
  logic [7:0]  o_err_count2, o_bit_count2;

  ber_checker dut (
    .clock(clock), .in_reset(in_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
    .i_rx_bit(i_rx_bit), .i_clear_counters(i_clear_counters), .o_lock(o_lock),
    .o_latency(o_latency), .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  ber_checker #(.NB_COUNT(8), .LOL_ERR_THR(256)) dut2 (
    .clock(clock), .in_reset(in_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
    .i_rx_bit(i_rx2), .i_clear_counters(clr2), .o_lock(o_lock2),
    .o_latency(o_latency2), .o_err_count(o_err_count2), .o_bit_count(o_bit_count2)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ns = 0;
  logic [14:0] lfsr = 15'h1;
  logic [63:0] hist = '0;
  logic        cur_ref = 1'b0;

  typedef struct {
    bit en; bit clr; bit inj;
    bit lock; int errc; int bitc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string p, input bit lk, input int lat, input int ec, input int bc);
    chk({p, ".lock"}, 64'(o_lock), 64'(lk));
    chk({p, ".latency"}, 64'(o_latency), 64'(lat));
    chk({p, ".err_count"}, o_err_count, 64'(ec));
    chk({p, ".bit_count"}, o_bit_count, 64'(bc));
  endtask

  function automatic logic tap(input int k);
    return (k == 0) ? cur_ref : hist[k-1];
  endfunction

  // One clock: drive at negedge, DUT samples at posedge, return at next negedge.
  task automatic cyc(input bit en, input bit clr, input bit inj, input int dly,
                     input bit inj2, input bit c2);
    logic nb;
    i_enable = en;
    i_clear_counters = clr;
    clr2 = c2;
    if (en) begin
      nb = lfsr[14] ^ lfsr[13];
      lfsr = {lfsr[13:0], nb};
      cur_ref = nb;
    end
    i_ref_bit = cur_ref;
    i_rx_bit = tap(dly) ^ inj;
    i_rx2 = cur_ref ^ inj2;
    @(posedge clock);
    if (en) begin
      hist = {hist[62:0], cur_ref};
      ns++;
    end
    @(negedge clock);
  endtask

  task automatic rst();
    in_reset = 1'b1;
    i_enable = 1'b1;
    i_clear_counters = 1'b1;
    clr2 = 1'b0;
    @(posedge clock);
    hist = '0;
    ns = 0;
    @(negedge clock);
    in_reset = 1'b0;
    i_clear_counters = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];
    int   p;
    bit   drop;

    tbl[0] = '{1, 0, 0, 1, 100, 10001};
    tbl[1] = '{1, 0, 1, 1, 101, 10002};
    tbl[2] = '{0, 0, 1, 1, 101, 10002};
    tbl[3] = '{0, 0, 0, 1, 101, 10002};
    tbl[4] = '{1, 1, 1, 1, 0, 0};
    tbl[5] = '{1, 0, 1, 1, 1, 1};
    tbl[6] = '{0, 1, 0, 1, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 0, 1};
    tbl[8] = '{1, 0, 0, 1, 0, 2};

    // Reset state
    rst();
    chk1("reset", 0, 0, 0, 0);
    chk("reset.lock2", 64'(o_lock2), 64'd0);

    // Acquisition: rx is ref delayed by 5
    for (int i = 0; i < 1535; i++) cyc(1, 0, 0, 5, 0, 0);
    chk("acq.lock_pre", 64'(o_lock), 64'd0);
    chk("acq.latency_pre", 64'(o_latency), 64'd5);
    cyc(1, 0, 0, 5, 0, 0);
    chk1("acq", 1, 5, 0, 0);
    chk("acq.lock2", 64'(o_lock2), 64'd1);
    chk("acq.latency2", 64'(o_latency2), 64'd0);

    // Sparse errors: one in every 100 bits
    drop = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      cyc(1, 0, (i % 100) == 99, 5, 0, 0);
      if (!o_lock) drop = 1'b1;
    end
    chk("sparse.no_drop", 64'(drop), 64'd0);
    chk1("sparse", 1, 5, 100, 10000);

    // Single-cycle vectors: enable gating and clear priority
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].en, tbl[i].clr, tbl[i].inj, 5, 0, 0);
      chk($sformatf("vec%0d.lock", i), 64'(o_lock), 64'(tbl[i].lock));
      chk($sformatf("vec%0d.err_count", i), o_err_count, 64'(tbl[i].errc));
      chk($sformatf("vec%0d.bit_count", i), o_bit_count, 64'(tbl[i].bitc));
    end

    // Saturation on the 8-bit instance with an all-error stream
    cyc(1, 0, 0, 5, 0, 1);
    for (int i = 0; i < 254; i++) cyc(1, 0, 0, 5, 1, 0);
    chk("sat.bit_254", 64'(o_bit_count2), 64'd254);
    cyc(1, 0, 0, 5, 1, 0);
    chk("sat.bit_255", 64'(o_bit_count2), 64'd255);
    chk("sat.err_255", 64'(o_err_count2), 64'd255);
    for (int i = 0; i < 45; i++) cyc(1, 0, 0, 5, 1, 0);
    chk("sat.bit_hold", 64'(o_bit_count2), 64'd255);
    chk("sat.err_hold", 64'(o_err_count2), 64'd255);
    chk("sat.lock2", 64'(o_lock2), 64'd1);

    // Loss of lock: clear, align to a window start, then invert a full window
    cyc(1, 1, 0, 5, 0, 0);
    p = 0;
    while (((ns - 1536) % 256) != 0) begin
      cyc(1, 0, 0, 5, 0, 0);
      p++;
    end
    chk1("lol.start", 1, 5, 0, p);
    for (int i = 0; i < 255; i++) cyc(1, 0, 1, 5, 0, 0);
    chk("lol.lock_pre", 64'(o_lock), 64'd1);
    cyc(1, 0, 1, 5, 0, 0);
    chk1("lol.drop", 0, 6, 256, p + 256);

    // Relock after wrapping 6..31,0..4
    for (int i = 0; i < 32 * 256 - 1; i++) cyc(1, 0, 0, 5, 0, 0);
    chk1("relock.pre", 0, 5, 256, p + 256);
    cyc(1, 0, 0, 5, 0, 0);
    chk1("relock", 1, 5, 0, 0);

    // Reset while locked, then acquire with enable toggling
    rst();
    chk1("rst_locked", 0, 0, 0, 0);
    chk("rst_locked.lock2", 64'(o_lock2), 64'd0);
    chk("rst_locked.bit2", 64'(o_bit_count2), 64'd0);
    for (int i = 0; i < 1535; i++) begin
      cyc(1, 0, 0, 5, 0, 0);
      cyc(0, 0, 0, 5, 0, 0);
    end
    chk("gate.lock_pre", 64'(o_lock), 64'd0);
    chk("gate.latency_pre", 64'(o_latency), 64'd5);
    cyc(1, 0, 0, 5, 0, 0);
    chk1("gate.lock", 1, 5, 0, 0);
    cyc(0, 0, 1, 5, 0, 0);
    chk1("gate.idle", 1, 5, 0, 0);
    cyc(1, 0, 0, 5, 0, 0);
    chk1("gate.count", 1, 5, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
